// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Brief    : 8N1 UART receiver driven by a 16x oversample tick (BCLK).
//             Samples mid-bit, strobes each good byte for one clk, flags
//             framing errors and rejects glitch start bits.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 BCLK,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  // Tick count of the mid start bit and of a full bit period.
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t                state, state_n;
  logic [TW-1:0]         tcnt, tcnt_n;
  logic [BW-1:0]         bcnt, bcnt_n;
  logic [DATA_BITS-1:0]  shreg, shreg_n;
  logic [DATA_BITS-1:0]  data_out_n;
  logic                  valid_n, ferr_n;
  logic                  rx_meta, rx_s;

  // Two-flop synchronizer for the asynchronous line; idles high out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State, counters, shift register and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      tcnt        <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state       <= state_n;
      tcnt        <= tcnt_n;
      bcnt        <= bcnt_n;
      shreg       <= shreg_n;
      data_out    <= data_out_n;
      data_valid  <= valid_n;
      framing_err <= ferr_n;
    end
  end

  // Next-state logic: counters advance only on BCLK; BREAK waits for line high.
  always_comb begin
    state_n    = state;
    tcnt_n     = tcnt;
    bcnt_n     = bcnt;
    shreg_n    = shreg;
    data_out_n = data_out;
    valid_n    = 1'b0;
    ferr_n     = 1'b0;
    case (state)
      S_IDLE: begin
        // BCLK on the entry cycle is deliberately not counted.
        if (!rx_s) begin
          state_n = S_START;
          tcnt_n  = '0;
        end
      end
      S_START: begin
        if (BCLK) begin
          if (tcnt == T_MID) begin
            tcnt_n = '0;
            if (!rx_s) begin
              state_n = S_DATA;
              bcnt_n  = '0;
            end else begin
              state_n = S_IDLE;  // glitch, not a real start bit
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (BCLK) begin
          if (tcnt == T_END) begin
            // LSB-first line order: shift right, new bit enters at MSB.
            shreg_n = DATA_BITS'({rx_s, shreg} >> 1);
            tcnt_n  = '0;
            bcnt_n  = bcnt + 1'b1;
            if (bcnt == B_LAST) begin
              state_n = S_STOP;
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (BCLK) begin
          if (tcnt == T_END) begin
            tcnt_n = '0;
            // Leaving at mid stop bit lets a back-to-back start edge be seen.
            if (rx_s) begin
              data_out_n = shreg;
              valid_n    = 1'b1;
              state_n    = S_IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = S_BREAK;
            end
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Brief    : Self-checking bench for uart_rx. Frames are built from bytes;
//             a byte is expected on data_valid exactly when its stop bit is 1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int BIT_CLK = 64;  // 16 ticks x 4 clk per tick

  logic       clk = 1'b0;
  logic       reset;
  logic       BCLK;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_err;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: bytes that must appear on data_valid, in order.
  logic [7:0] exp_q[$];
  // Observed strobes.
  logic [7:0] got_q[$];
  int         fe_cnt   = 0;
  int         both_cnt = 0;

  logic bclk_en = 1'b1;
  int   div     = 0;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .BCLK       (BCLK),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .framing_err(framing_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // BCLK: one-clk tick every 4 clk; the divider freezes while disabled.
  initial begin
    BCLK = 1'b0;
    forever begin
      @(negedge clk);
      if (bclk_en) begin
        div  = (div + 1) % 4;
        BCLK = (div == 0);
      end else begin
        BCLK = 1'b0;
      end
    end
  end

  // Strobe monitor.
  always @(negedge clk) begin
    if (data_valid) got_q.push_back(data_out);
    if (framing_err) fe_cnt = fe_cnt + 1;
    if (data_valid && framing_err) both_cnt = both_cnt + 1;
  end

  task automatic send_bit(input logic b, input int clks);
    rx = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    send_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) send_bit(d[i], BIT_CLK);
    send_bit(stop_ok, BIT_CLK);
    if (stop_ok) exp_q.push_back(d);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++;
    if (data_out !== 8'h00) begin
      tests_failed++; $display("FAIL reset_data_out: got %h expected 00", data_out);
    end
    tests_run++;
    if (data_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_data_valid: got %b expected 0", data_valid);
    end
    tests_run++;
    if (framing_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_framing_err: got %b expected 0", framing_err);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_glitch();
    int g0 = got_q.size();
    int f0 = fe_cnt;
    send_bit(1'b0, 12);
    send_bit(1'b1, 8);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL glitch_busy_start: got %b expected 1", busy);
    end
    send_bit(1'b1, 80);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL glitch_busy_idle: got %b expected 0", busy);
    end
    tests_run++;
    if (got_q.size() != g0) begin
      tests_failed++; $display("FAIL glitch_no_valid: got %0d strobes expected 0", got_q.size() - g0);
    end
    tests_run++;
    if (fe_cnt != f0) begin
      tests_failed++; $display("FAIL glitch_no_ferr: got %0d expected 0", fe_cnt - f0);
    end
    tests_run++;
    if (data_out !== 8'h00) begin
      tests_failed++; $display("FAIL glitch_data_out: got %h expected 00", data_out);
    end
  endtask

  // Compare all strobes since the given queue marks against the model.
  task automatic compare_since(input string name, input int g0, input int e0);
    int ng = got_q.size() - g0;
    int ne = exp_q.size() - e0;
    tests_run++;
    if (ng != ne) begin
      tests_failed++; $display("FAIL %s_count: got %0d strobes expected %0d", name, ng, ne);
    end
    for (int i = 0; i < ne && i < ng; i++) begin
      tests_run++;
      if (got_q[g0+i] !== exp_q[e0+i]) begin
        tests_failed++;
        $display("FAIL %s_byte%0d: got %h expected %h", name, i, got_q[g0+i], exp_q[e0+i]);
      end
    end
  endtask

  task automatic test_frame();
    int g0 = got_q.size();
    int e0 = exp_q.size();
    int f0 = fe_cnt;
    send_frame(8'hA5, 1'b1);
    for (int k = 0; k < 4; k++) begin
      send_bit(1'b1, $urandom_range(0, 40));
      send_frame(8'($urandom), 1'b1);
    end
    send_bit(1'b1, 40);
    compare_since("frame", g0, e0);
    tests_run++;
    if (fe_cnt != f0) begin
      tests_failed++; $display("FAIL frame_no_ferr: got %0d expected 0", fe_cnt - f0);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL frame_busy_after: got %b expected 0", busy);
    end
  endtask

  task automatic test_framing();
    int g0 = got_q.size();
    int f0 = fe_cnt;
    logic [7:0] d0 = data_out;
    send_frame(8'h3C, 1'b0);
    send_bit(1'b0, 3 * BIT_CLK);
    tests_run++;
    if (fe_cnt - f0 != 1) begin
      tests_failed++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt - f0);
    end
    tests_run++;
    if (got_q.size() != g0) begin
      tests_failed++; $display("FAIL ferr_no_valid: got %0d strobes expected 0", got_q.size() - g0);
    end
    tests_run++;
    if (data_out !== d0) begin
      tests_failed++; $display("FAIL ferr_data_out: got %h expected %h", data_out, d0);
    end
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL ferr_busy_break: got %b expected 1", busy);
    end
    send_bit(1'b1, 10);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL ferr_busy_release: got %b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int g0 = got_q.size();
    int e0 = exp_q.size();
    int f0 = fe_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'($urandom), 1'b1);
    send_frame(8'($urandom), 1'b1);
    send_bit(1'b1, 40);
    compare_since("b2b", g0, e0);
    tests_run++;
    if (fe_cnt != f0) begin
      tests_failed++; $display("FAIL b2b_no_ferr: got %0d expected 0", fe_cnt - f0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d = 8'h5A;
    int g0, e0;
    int f0 = fe_cnt;
    g0 = got_q.size();
    send_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) send_bit(d[i], BIT_CLK);
    send_bit(d[4], 32);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send_bit(1'b1, 2 * BIT_CLK);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_busy: got %b expected 0", busy);
    end
    tests_run++;
    if (data_out !== 8'h00) begin
      tests_failed++; $display("FAIL rstmid_data_out: got %h expected 00", data_out);
    end
    tests_run++;
    if (got_q.size() != g0 || fe_cnt != f0) begin
      tests_failed++;
      $display("FAIL rstmid_no_strobe: got %0d valid %0d ferr expected 0 0", got_q.size() - g0, fe_cnt - f0);
    end
    g0 = got_q.size();
    e0 = exp_q.size();
    send_frame(8'hC3, 1'b1);
    send_bit(1'b1, 40);
    compare_since("rstmid", g0, e0);
  endtask

  task automatic test_bclk_stall();
    logic [7:0] d = 8'h81;
    int g0 = got_q.size();
    int e0 = exp_q.size();
    int ph = $urandom_range(8, 56);
    send_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 3; i++) send_bit(d[i], BIT_CLK);
    send_bit(d[3], ph);
    bclk_en = 1'b0;
    send_bit(d[3], 500);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL stall_busy: got %b expected 1", busy);
    end
    tests_run++;
    if (got_q.size() != g0) begin
      tests_failed++; $display("FAIL stall_no_valid: got %0d strobes expected 0", got_q.size() - g0);
    end
    bclk_en = 1'b1;
    send_bit(d[3], BIT_CLK - ph);
    for (int i = 4; i < 8; i++) send_bit(d[i], BIT_CLK);
    send_bit(1'b1, BIT_CLK);
    exp_q.push_back(d);
    send_bit(1'b1, 40);
    compare_since("stall", g0, e0);
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    test_reset();
    test_glitch();
    test_frame();
    test_framing();
    test_back_to_back();
    test_reset_mid();
    test_bclk_stall();
    tests_run++;
    if (both_cnt != 0) begin
      tests_failed++; $display("FAIL strobe_exclusive: got %0d overlaps expected 0", both_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
